// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM encoding and lane helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    function automatic logic legal_f3(input logic st, input logic [2:0] f3);
        return st ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                  : (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111);
    endfunction

    // funct3[1:0] carries the access size for every legal code
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        return f3[1:0] == 2'b00 ? BE_B << a :
               f3[1:0] == 2'b01 ? BE_H << {a[1], 1'b0} : BE_W;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
        return f3[1:0] == 2'b00 ? {4{wd[7:0]}} :
               f3[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/half/word of a bus word and extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [31:0] sh;

    always_comb begin
        sh   = word >> {addr_lo, 3'b000};
        data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
               funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
               funct3 == F3_BU ? {24'b0, sh[7:0]} :
               funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
    end

endmodule

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: single-outstanding load/store initiator with alignment,
// funct3 legality and bus-timeout checking.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_misaligned,
    output logic              resp_illegal,
    output logic              resp_bus_err,
    output logic [ADDR_W-1:0] resp_fault_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              st_q, mis_q, ill_q, berr_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q, ext;
    logic [4:0]        rd_q;
    logic              busy, done, timeout, ill_in, mis_in;

    always_comb begin
        ill_in  = !legal_f3(req_is_store, req_funct3);
        mis_in  = misaligned(req_funct3, req_addr[1:0]);
        busy    = state == REQ || state == WAIT;
        done    = (state == REQ && mem_gnt && mem_rvalid) || (state == WAIT && mem_rvalid);
        timeout = busy && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    end

    lsu_load_align u_align (
        .funct3  (f3_q),
        .addr_lo (addr_q[1:0]),
        .word    (mem_rdata),
        .data    (ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !req_valid ? IDLE : (ill_in || mis_in) ? RESP : REQ;
            REQ:     state_nx = (done || timeout) ? RESP : mem_gnt ? WAIT : REQ;
            WAIT:    state_nx = (done || timeout) ? RESP : WAIT;
            RESP:    state_nx = resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            st_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            cnt <= busy ? cnt + 1'b1 : '0;
            if (state == IDLE && req_valid) begin
                st_q    <= req_is_store;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
                ill_q   <= ill_in;
                mis_q   <= !ill_in && mis_in;
                berr_q  <= 1'b0;
                rdata_q <= '0;
            end
            if (done && !st_q)
                rdata_q <= ext;
            // a completion in the final allowed cycle still wins over the timeout
            if (timeout && !done)
                berr_q <= 1'b1;
        end
    end

    always_comb begin
        req_ready       = state == IDLE;
        mem_req         = state == REQ;
        mem_we          = mem_req && st_q;
        mem_addr        = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_be          = mem_req ? byte_en(f3_q, addr_q[1:0]) : '0;
        mem_wdata       = mem_we ? lane_data(f3_q, wdata_q) : '0;
        resp_valid      = state == RESP;
        resp_rdata      = resp_valid ? rdata_q : '0;
        resp_rd         = resp_valid ? rd_q : '0;
        resp_misaligned = resp_valid && mis_q;
        resp_illegal    = resp_valid && ill_q;
        resp_bus_err    = resp_valid && berr_q;
        resp_fault_addr = (resp_valid && (mis_q || ill_q || berr_q)) ? addr_q : '0;
    end

endmodule
